// File: rtl/alu_op_pipe.sv
// -----------------------------------------------------------------------------
// alu_op_pipe
//
// Two-stage registered issue/capture wrapper around an external combinational
// ALU. Operations arrive on a valid/ready handshake and land in the stage-1
// operand register, which drives the ALU directly. One cycle later the ALU
// result, a zero flag and a divide-by-zero error are captured into the stage-2
// output register and offered downstream on a second valid/ready handshake.
// Both stages can advance in the same cycle, so the block sustains one
// operation per cycle while downstream is ready.
//
// Ports
//   clk         : single clock, all state on the rising edge
//   rst_n       : asynchronous active-low reset
//   in_valid    : upstream operation valid
//   in_ready    : block accepts an operation this cycle
//   in_a, in_b  : operands (DATA_WID)
//   in_sel      : 4-bit ALU opcode, passed through unfiltered
//   alu_a/b/sel : stage-1 register contents, driven to the ALU
//   alu_result  : combinational ALU output, sampled on the S1->S2 edge
//   out_valid   : stage-2 result valid
//   out_ready   : downstream accepts the result
//   out_result  : captured result (forced to 0 on divide-by-zero)
//   out_zero    : out_result == 0
//   out_dz_err  : captured op was a divide with B == 0
//   ops_done    : wrapping count of results accepted downstream
// -----------------------------------------------------------------------------
module alu_op_pipe #(
  parameter int DATA_WID = 4,
  parameter int CNT_WID  = 16
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_WID-1:0] in_a,
  input  logic [DATA_WID-1:0] in_b,
  input  logic [3:0]          in_sel,

  output logic [DATA_WID-1:0] alu_a,
  output logic [DATA_WID-1:0] alu_b,
  output logic [3:0]          alu_sel,
  input  logic [DATA_WID-1:0] alu_result,

  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] out_result,
  output logic                out_zero,
  output logic                out_dz_err,

  output logic [CNT_WID-1:0]  ops_done
);

  localparam logic [3:0] SEL_DIV = 4'b0011;

  // Stage 1: operand register feeding the ALU
  logic                s1_valid_q, s1_valid_d;
  logic [DATA_WID-1:0] s1_a_q,     s1_a_d;
  logic [DATA_WID-1:0] s1_b_q,     s1_b_d;
  logic [3:0]          s1_sel_q,   s1_sel_d;

  // Stage 2: captured result register
  logic                s2_valid_q,  s2_valid_d;
  logic [DATA_WID-1:0] s2_result_q, s2_result_d;
  logic                s2_zero_q,   s2_zero_d;
  logic                s2_dz_q,     s2_dz_d;

  logic [CNT_WID-1:0]  ops_done_q,  ops_done_d;

  // Handshake terms
  logic s2_take;   // S2 is empty or is being drained this cycle
  logic s1_move;   // S1 contents advance into S2 this cycle
  logic in_fire;   // upstream handshake completes
  logic out_fire;  // downstream handshake completes
  logic div_by_zero;
  logic [DATA_WID-1:0] capture_result;

  // NOTE: in_ready looks only at downstream state, never at in_valid, so there
  // is no combinational loop through an upstream that waits on ready.
  assign s2_take  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_take;
  assign s1_move  = s1_valid_q && s2_take;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  // A divide by zero replaces whatever the ALU drives with 0, so an undefined
  // ALU output can never reach the result register.
  assign div_by_zero    = (s1_sel_q == SEL_DIV) && (s1_b_q == '0);
  assign capture_result = div_by_zero ? '0 : alu_result;

  // NOTE: every always_comb output gets its hold value first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_sel_d   = s1_sel_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_sel_d   = in_sel;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_zero_d   = s2_zero_q;
    s2_dz_d     = s2_dz_q;

    if (s1_move) begin
      s2_valid_d  = 1'b1;
      s2_result_d = capture_result;
      // Zero is judged on the masked value, so a divide-by-zero reads as zero.
      s2_zero_d   = (capture_result == '0);
      s2_dz_d     = div_by_zero;
    end else if (out_ready) begin
      s2_valid_d  = 1'b0;
    end
  end

  always_comb begin
    ops_done_d = ops_done_q;
    if (out_fire) begin
      ops_done_d = ops_done_q + 1'b1;  // wraps naturally at all-ones
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  // Data registers are reset too: their reset values are visible on alu_* and
  // out_* and must be defined, not just the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_sel_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b0;
      s2_dz_q     <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_sel_q    <= s1_sel_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_zero_q   <= s2_zero_d;
      s2_dz_q     <= s2_dz_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign alu_a      = s1_a_q;
  assign alu_b      = s1_b_q;
  assign alu_sel    = s1_sel_q;
  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_zero   = s2_zero_q;
  assign out_dz_err = s2_dz_q;
  assign ops_done   = ops_done_q;

endmodule
